// File: rtl/ibex_pkg_pext.sv
`default_nettype none
// ============================================================================
// Module  : ibex_pkg_pext
// Brief   : Shared types and constants for the P-ext multiply-accumulate unit.
// Revision: 1.0 - initial release
// ============================================================================
package ibex_pkg_pext;

    typedef enum logic [3:0] {
        ZPN_NONE   = 4'd0,
        ZPN_ADD16  = 4'd1,
        ZPN_SUB16  = 4'd2,
        ZPN_MADDR32 = 4'd3,
        ZPN_MSUBR32 = 4'd4,
        ZPN_KMMAC  = 4'd5,
        ZPN_KMMACU = 4'd6,
        ZPN_KMMSB  = 4'd7,
        ZPN_KMMSBU = 4'd8
    } zpn_op_e;

    typedef enum logic [2:0] {
        MAC_IDLE = 3'd0,
        MAC_LL   = 3'd1,
        MAC_LH   = 3'd2,
        MAC_HL   = 3'd3,
        MAC_HH   = 3'd4,
        MAC_ACC  = 3'd5,
        MAC_DONE = 3'd6
    } pext_mac_state_e;

    localparam int unsigned PEXT_MAC_STEPS = 4;

    localparam logic [31:0] PEXT_SAT_MAX32 = 32'h7FFF_FFFF;
    localparam logic [31:0] PEXT_SAT_MIN32 = 32'h8000_0000;

    function automatic logic pext_is_mac(zpn_op_e op);
        return (op == ZPN_MADDR32) || (op == ZPN_MSUBR32) ||
               (op == ZPN_KMMAC)   || (op == ZPN_KMMACU)  ||
               (op == ZPN_KMMSB)   || (op == ZPN_KMMSBU);
    endfunction

    // K-ops take the high word of the product and saturate
    function automatic logic pext_is_k(zpn_op_e op);
        return (op == ZPN_KMMAC) || (op == ZPN_KMMACU) ||
               (op == ZPN_KMMSB) || (op == ZPN_KMMSBU);
    endfunction

    function automatic logic pext_is_round(zpn_op_e op);
        return (op == ZPN_KMMACU) || (op == ZPN_KMMSBU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_pext_mul17.sv
`default_nettype none
// ============================================================================
// Module  : ibex_pext_mul17
// Brief   : Combinational 17x17 signed multiplier with half-word operand
//           selection driven by the MAC sequencing state.
// Revision: 1.0 - initial release
// ============================================================================
module ibex_pext_mul17
    import ibex_pkg_pext::*;
(
    input  pext_mac_state_e     i_state,
    input  logic [31:0]         i_op_a,
    input  logic [31:0]         i_op_b,
    output logic signed [33:0]  o_prod
);

    logic               w_a_hi;
    logic               w_b_hi;
    logic signed [16:0] w_x;
    logic signed [16:0] w_y;

    always_comb begin
        w_a_hi = 1'b0;
        w_b_hi = 1'b0;
        case (i_state)
            MAC_LH: w_b_hi = 1'b1;
            MAC_HL: w_a_hi = 1'b1;
            MAC_HH: begin
                w_a_hi = 1'b1;
                w_b_hi = 1'b1;
            end
            default: ;
        endcase
    end

    // Low halves are unsigned magnitudes, high halves carry the sign
    assign w_x = w_a_hi ? {i_op_a[31], i_op_a[31:16]} : {1'b0, i_op_a[15:0]};
    assign w_y = w_b_hi ? {i_op_b[31], i_op_b[31:16]} : {1'b0, i_op_b[15:0]};

    assign o_prod = 34'(w_x) * 34'(w_y);

endmodule
`default_nettype wire

// File: rtl/ibex_alu_pext_mac.sv
`default_nettype none
// ============================================================================
// Module  : ibex_alu_pext_mac
// Brief   : Multi-cycle P-ext 32x32 multiply-accumulate (MADDR32/MSUBR32/
//           KMMAC[u]/KMMSB[u]) built on an iterated 17x17 multiplier.
// Revision: 1.0 - initial release
// ============================================================================
module ibex_alu_pext_mac
    import ibex_pkg_pext::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        kill_i,
    input  zpn_op_e     zpn_operator_i,
    input  logic [1:0]  alu_sub_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [31:0] op_c_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        ov_o
);

    pext_mac_state_e    r_state;
    pext_mac_state_e    w_state_d;
    logic               w_start;

    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_c;
    zpn_op_e            r_op;
    logic               r_sub;
    logic signed [63:0] r_acc;
    logic [31:0]        r_result;
    logic               r_ov;

    logic signed [33:0] w_prod;
    logic signed [63:0] w_pp;
    logic [63:0]        w_acc_rnd;
    logic [31:0]        w_hi;
    logic [32:0]        w_sum33;
    logic [31:0]        w_lo_res;
    logic [31:0]        w_res_d;
    logic               w_ov_d;
    logic               w_unused_sub_hi;

    assign w_unused_sub_hi = alu_sub_i[1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= MAC_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_start   = 1'b0;
        if (kill_i) begin
            w_state_d = MAC_IDLE;
        end else begin
            case (r_state)
                MAC_IDLE: begin
                    if (en_i && pext_is_mac(zpn_operator_i)) begin
                        w_state_d = MAC_LL;
                        w_start   = 1'b1;
                    end
                end
                MAC_LL:   w_state_d = MAC_LH;
                MAC_LH:   w_state_d = MAC_HL;
                MAC_HL:   w_state_d = MAC_HH;
                MAC_HH:   w_state_d = MAC_ACC;
                MAC_ACC:  w_state_d = MAC_DONE;
                MAC_DONE: w_state_d = MAC_IDLE;
                default:  w_state_d = MAC_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Partial products
    // ------------------------------------------------------------------
    ibex_pext_mul17 u_mul17 (
        .i_state (r_state),
        .i_op_a  (r_a),
        .i_op_b  (r_b),
        .o_prod  (w_prod)
    );

    assign w_pp = 64'(w_prod);

    // ------------------------------------------------------------------
    // Accumulate / round / saturate
    // ------------------------------------------------------------------
    assign w_acc_rnd = r_acc + (pext_is_round(r_op) ? 64'h0000_0000_8000_0000 : 64'd0);
    assign w_hi      = w_acc_rnd[63:32];
    assign w_sum33   = r_sub ? ({r_c[31], r_c} - {w_hi[31], w_hi})
                             : ({r_c[31], r_c} + {w_hi[31], w_hi});
    assign w_lo_res  = r_sub ? (r_c - r_acc[31:0]) : (r_c + r_acc[31:0]);

    always_comb begin
        w_res_d = w_lo_res;
        w_ov_d  = 1'b0;
        if (pext_is_k(r_op)) begin
            w_res_d = w_sum33[31:0];
            // Differing top two bits means the 33-bit sum left the 32-bit range
            if (w_sum33[32] != w_sum33[31]) begin
                w_ov_d  = 1'b1;
                w_res_d = w_sum33[32] ? PEXT_SAT_MIN32 : PEXT_SAT_MAX32;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_op     <= ZPN_NONE;
            r_sub    <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_ov     <= 1'b0;
        end else begin
            if (w_start) begin
                r_a   <= op_a_i;
                r_b   <= op_b_i;
                r_c   <= op_c_i;
                r_op  <= zpn_operator_i;
                r_sub <= alu_sub_i[0];
            end
            case (r_state)
                MAC_LL:         r_acc <= w_pp;
                MAC_LH, MAC_HL: r_acc <= r_acc + (w_pp <<< 16);
                MAC_HH:         r_acc <= r_acc + (w_pp <<< 32);
                MAC_ACC: begin
                    if (!kill_i) begin
                        r_result <= w_res_d;
                        r_ov     <= w_ov_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (r_state != MAC_IDLE);
    assign valid_o  = (r_state == MAC_DONE);
    assign result_o = r_result;
    assign ov_o     = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_ibex_alu_pext_mac.sv
`default_nettype none
// ============================================================================
// Module  : tb_ibex_alu_pext_mac
// Brief   : Directed self-checking bench for the P-ext MAC unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ibex_alu_pext_mac;
    import ibex_pkg_pext::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        kill;
    zpn_op_e     op;
    logic [1:0]  sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic        ov;

    int n_total;
    int n_bad;

    ibex_alu_pext_mac dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .kill_i         (kill),
        .zpn_operator_i (op),
        .alu_sub_i      (sub),
        .op_a_i         (a),
        .op_b_i         (b),
        .op_c_i         (c),
        .busy_o         (busy),
        .valid_o        (valid),
        .result_o       (result),
        .ov_o           (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op at a negedge, follow it for 10 cycles, check latency,
    // single valid pulse, no restart from DONE, and the result/ov.
    task automatic run_op(input string tag, input zpn_op_e o, input logic [1:0] s,
                          input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc,
                          input logic [31:0] exp_res, input logic exp_ov);
        int vk;
        int npulse;
        @(negedge clk);
        en = 1'b1; op = o; sub = s; a = va; b = vb; c = vc;
        vk = -1;
        npulse = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (valid) begin
                npulse++;
                if (vk < 0) vk = k;
            end
            if (vk > 0 && k == vk + 1) begin
                chk({tag, "_idle_after_done"}, 32'(busy), 32'd0);
                en = 1'b0;
            end
        end
        en = 1'b0;
        chk({tag, "_latency"}, 32'(vk), 32'd6);
        chk({tag, "_pulses"}, 32'(npulse), 32'd1);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_ov"}, 32'(ov), 32'(exp_ov));
    endtask

    initial begin
        int nvalid;
        n_total = 0;
        n_bad   = 0;
        rst_n = 1'b0; en = 1'b0; kill = 1'b0; op = ZPN_NONE; sub = 2'b00;
        a = '0; b = '0; c = '0;

        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op("maddr",   ZPN_MADDR32, 2'b00, 32'd3, 32'd5, 32'd7, 32'h0000_0016, 1'b0);
        run_op("msubr",   ZPN_MSUBR32, 2'b11, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h0000_0002, 1'b0);
        run_op("kmmac_sat", ZPN_KMMAC, 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
               32'h7FFF_FFFF, 1'b1);
        run_op("kmmsb_sat", ZPN_KMMSB, 2'b11, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
               32'h8000_0000, 1'b1);
        run_op("kmmac",   ZPN_KMMAC,  2'b00, 32'h0001_0000, 32'h0000_8000, 32'd0, 32'd0, 1'b0);
        run_op("kmmacu",  ZPN_KMMACU, 2'b00, 32'h0001_0000, 32'h0000_8000, 32'd0, 32'd1, 1'b0);
        run_op("kmmsbu",  ZPN_KMMSBU, 2'b11, 32'h0001_0000, 32'h0000_8000, 32'd5, 32'd4, 1'b0);
        // -2 * 3 = -6, high word -1: 10 + (-1) = 9
        run_op("kmmac_neg", ZPN_KMMAC, 2'b00, 32'hFFFF_FFFE, 32'd3, 32'd10, 32'd9, 1'b0);

        // Non-MAC op must not start
        @(negedge clk);
        en = 1'b1; op = ZPN_ADD16; sub = 2'b00;
        @(negedge clk);
        chk("nonmac_busy", 32'(busy), 32'd0);
        en = 1'b0;

        // Kill in the same cycle as a start
        en = 1'b1; kill = 1'b1; op = ZPN_MADDR32; a = 32'd9; b = 32'd9; c = 32'd9;
        @(negedge clk);
        chk("kill_start_busy", 32'(busy), 32'd0);
        en = 1'b0; kill = 1'b0;

        // Kill in MUL_HL
        @(negedge clk);
        en = 1'b1; op = ZPN_MADDR32; sub = 2'b00; a = 32'd5; b = 32'd5; c = 32'd0;
        nvalid = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        kill = 1'b1; en = 1'b0;
        @(negedge clk);
        chk("kill_busy", 32'(busy), 32'd0);
        kill = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        chk("kill_no_valid", 32'(nvalid), 32'd0);
        chk("kill_res_held", result, 32'd9);
        chk("kill_ov_held", 32'(ov), 32'd0);

        run_op("after_kill", ZPN_MADDR32, 2'b00, 32'd1, 32'd1, 32'd1, 32'd2, 1'b0);

        // Reset asserted in MUL_LH
        @(negedge clk);
        en = 1'b1; op = ZPN_KMMAC; sub = 2'b00;
        a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; c = 32'h7FFF_FFFF;
        nvalid = 0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        rst_n = 1'b0; en = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_res", result, 32'd0);
        chk("midrst_ov", 32'(ov), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        chk("midrst_no_valid", 32'(nvalid), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);

        run_op("after_rst", ZPN_MADDR32, 2'b00, 32'd3, 32'd5, 32'd7, 32'h0000_0016, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
